// File: rtl/alarm_zone_ctrl.sv
// Multi-zone alarm controller: arm/disarm FSM with exit/entry delays, bounded siren and sticky trip record.
// Optional build macro ALARM_INSTANT_Z0_EN makes zone 0 an instant (no entry delay) zone.
module alarm_zone_ctrl #(
   parameter int N_ZONES   = 4,
   parameter int CNT_W     = 8,
   parameter int EXIT_DLY  = 16,
   parameter int ENTRY_DLY = 16,
   parameter int SIREN_CYC = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               seq,
   input  logic [N_ZONES-1:0] mov,
   input  logic [N_ZONES-1:0] zone_mask,
   output logic [2:0]         state,
   output logic               armed,
   output logic               siren,
   output logic [N_ZONES-1:0] trip_zones
);

   typedef enum logic [2:0] {
      UNARMED = 3'b000,
      EXIT    = 3'b001,
      ARMED   = 3'b010,
      ENTRY   = 3'b011,
      ALARM   = 3'b100
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DLY - 1);
   localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DLY - 1);
   localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_CYC - 1);

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               siren_r;
   logic               armed_r;
   logic [N_ZONES-1:0] trip_r;
   logic [N_ZONES-1:0] act_s;
   logic               instant_s;
   logic               cnt_zero_s;

   assign act_s      = mov & ~zone_mask;
   assign cnt_zero_s = (cnt_r == CNT_ZERO);

`ifdef ALARM_INSTANT_Z0_EN
   assign instant_s = act_s[0];
`else
   assign instant_s = 1'b0;
`endif

   // Arm/disarm FSM; enable outranks counter expiry, which outranks zone activity.
   // While a keypad strobe is being served, zone activity is not recorded that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= UNARMED;
         cnt_r   <= CNT_ZERO;
         siren_r <= 1'b0;
         armed_r <= 1'b0;
         trip_r  <= {N_ZONES{1'b0}};
      end else begin
         case (state_r)
            UNARMED: begin
               siren_r <= 1'b0;
               armed_r <= 1'b0;
               if (enable && seq) begin
                  state_r <= EXIT;
                  cnt_r   <= EXIT_LD;
                  trip_r  <= {N_ZONES{1'b0}};
               end else begin
                  cnt_r   <= CNT_ZERO;
               end
            end
            EXIT: begin
               siren_r <= 1'b0;
               if (enable && seq) begin
                  state_r <= UNARMED;
                  cnt_r   <= CNT_ZERO;
                  armed_r <= 1'b0;
               end else if (enable) begin
                  armed_r <= 1'b0;
               end else if (cnt_zero_s) begin
                  state_r <= ARMED;
                  armed_r <= 1'b1;
               end else begin
                  cnt_r   <= cnt_r - CNT_ONE;
                  armed_r <= 1'b0;
               end
            end
            ARMED: begin
               if (enable && seq) begin
                  state_r <= UNARMED;
                  cnt_r   <= CNT_ZERO;
                  siren_r <= 1'b0;
                  armed_r <= 1'b0;
               end else if (enable) begin
                  state_r <= ALARM;
                  cnt_r   <= SIREN_LD;
                  siren_r <= 1'b1;
                  armed_r <= 1'b0;
               end else if (instant_s) begin
                  state_r <= ALARM;
                  cnt_r   <= SIREN_LD;
                  siren_r <= 1'b1;
                  armed_r <= 1'b0;
                  trip_r  <= trip_r | act_s;
               end else if (|act_s) begin
                  state_r <= ENTRY;
                  cnt_r   <= ENTRY_LD;
                  siren_r <= 1'b0;
                  armed_r <= 1'b1;
                  trip_r  <= trip_r | act_s;
               end else begin
                  cnt_r   <= CNT_ZERO;
                  siren_r <= 1'b0;
                  armed_r <= 1'b1;
               end
            end
            ENTRY: begin
               if (enable && seq) begin
                  state_r <= UNARMED;
                  cnt_r   <= CNT_ZERO;
                  siren_r <= 1'b0;
                  armed_r <= 1'b0;
               end else if (enable) begin
                  state_r <= ALARM;
                  cnt_r   <= SIREN_LD;
                  siren_r <= 1'b1;
                  armed_r <= 1'b0;
               end else begin
                  trip_r  <= trip_r | act_s;
                  if (instant_s || cnt_zero_s) begin
                     state_r <= ALARM;
                     cnt_r   <= SIREN_LD;
                     siren_r <= 1'b1;
                     armed_r <= 1'b0;
                  end else begin
                     cnt_r   <= cnt_r - CNT_ONE;
                     siren_r <= 1'b0;
                     armed_r <= 1'b1;
                  end
               end
            end
            ALARM: begin
               armed_r <= 1'b0;
               if (enable && seq) begin
                  state_r <= UNARMED;
                  cnt_r   <= CNT_ZERO;
                  siren_r <= 1'b0;
               end else if (enable) begin
                  cnt_r   <= SIREN_LD;
                  siren_r <= 1'b1;
               end else begin
                  trip_r  <= trip_r | act_s;
                  // Counter parks at zero once the siren period is spent; alarm stays silent.
                  if (cnt_zero_s) begin
                     siren_r <= 1'b0;
                  end else begin
                     cnt_r   <= cnt_r - CNT_ONE;
                  end
               end
            end
            default: begin
               state_r <= UNARMED;
               cnt_r   <= CNT_ZERO;
               siren_r <= 1'b0;
               armed_r <= 1'b0;
            end
         endcase
      end
   end

   assign state      = state_r;
   assign armed      = armed_r;
   assign siren      = siren_r;
   assign trip_zones = trip_r;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Self-checking bench for alarm_zone_ctrl: directed scenarios plus random traffic
// against a deadline-based reference model.
module tb_alarm_zone_ctrl;

   localparam int N         = 4;
   localparam int EXIT_DLY  = 16;
   localparam int ENTRY_DLY = 16;
   localparam int SIREN_CYC = 64;
`ifdef ALARM_INSTANT_Z0_EN
   localparam bit INSTANT = 1'b1;
`else
   localparam bit INSTANT = 1'b0;
`endif

   localparam logic [2:0] S_UNARMED = 3'b000;
   localparam logic [2:0] S_EXIT    = 3'b001;
   localparam logic [2:0] S_ARMED   = 3'b010;
   localparam logic [2:0] S_ENTRY   = 3'b011;
   localparam logic [2:0] S_ALARM   = 3'b100;

   logic         clk;
   logic         rst_n;
   logic         enable;
   logic         seq;
   logic [N-1:0] mov;
   logic [N-1:0] zone_mask;
   logic [2:0]   state;
   logic         armed;
   logic         siren;
   logic [N-1:0] trip_zones;

   int errors = 0;
   int checks = 0;

   // reference model: edge index and absolute deadlines instead of a down-counter
   int           e_idx = 0;
   logic [2:0]   m_st;
   logic [N-1:0] m_trip;
   int           m_deadline;
   int           m_siren_end;

   alarm_zone_ctrl #(
      .N_ZONES(N), .CNT_W(8), .EXIT_DLY(EXIT_DLY), .ENTRY_DLY(ENTRY_DLY), .SIREN_CYC(SIREN_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .seq(seq), .mov(mov),
      .zone_mask(zone_mask), .state(state), .armed(armed), .siren(siren),
      .trip_zones(trip_zones)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_st        = S_UNARMED;
      m_trip      = '0;
      m_deadline  = 0;
      m_siren_end = 0;
   endtask

   task automatic model_step(input logic en, input logic sq, input logic [N-1:0] mv,
                             input logic [N-1:0] mk);
      logic [N-1:0] act;
      e_idx++;
      act = mv & ~mk;
      case (m_st)
         S_UNARMED: if (en && sq) begin
            m_st = S_EXIT; m_deadline = e_idx + EXIT_DLY; m_trip = '0;
         end
         S_EXIT: begin
            if (en && sq) m_st = S_UNARMED;
            else if (en) m_deadline = m_deadline + 1;
            else if (e_idx == m_deadline) m_st = S_ARMED;
         end
         S_ARMED: begin
            if (en && sq) m_st = S_UNARMED;
            else if (en) begin m_st = S_ALARM; m_siren_end = e_idx + SIREN_CYC; end
            else if (act != '0) begin
               m_trip = m_trip | act;
               if (INSTANT && act[0]) begin
                  m_st = S_ALARM; m_siren_end = e_idx + SIREN_CYC;
               end else begin
                  m_st = S_ENTRY; m_deadline = e_idx + ENTRY_DLY;
               end
            end
         end
         S_ENTRY: begin
            if (en && sq) m_st = S_UNARMED;
            else if (en) begin m_st = S_ALARM; m_siren_end = e_idx + SIREN_CYC; end
            else begin
               m_trip = m_trip | act;
               if ((INSTANT && act[0]) || e_idx == m_deadline) begin
                  m_st = S_ALARM; m_siren_end = e_idx + SIREN_CYC;
               end
            end
         end
         S_ALARM: begin
            if (en && sq) m_st = S_UNARMED;
            else if (en) m_siren_end = e_idx + SIREN_CYC;
            else m_trip = m_trip | act;
         end
         default: m_st = S_UNARMED;
      endcase
   endtask

   task automatic check_model(input string tag);
      logic exp_siren;
      logic exp_armed;
      exp_siren = (m_st == S_ALARM) && (e_idx < m_siren_end);
      exp_armed = (m_st == S_ARMED) || (m_st == S_ENTRY);
      check({tag, ".state"}, 16'(state), 16'(m_st));
      check({tag, ".armed"}, 16'(armed), 16'(exp_armed));
      check({tag, ".siren"}, 16'(siren), 16'(exp_siren));
      check({tag, ".trip"},  16'(trip_zones), 16'(m_trip));
   endtask

   task automatic step(input string tag, input logic en, input logic sq,
                       input logic [N-1:0] mv, input logic [N-1:0] mk);
      enable = en; seq = sq; mov = mv; zone_mask = mk;
      @(posedge clk);
      model_step(en, sq, mv, mk);
      #1;
      check_model(tag);
   endtask

   task automatic arm_and_wait(input string tag);
      step({tag, ".arm"}, 1'b1, 1'b1, 4'b0000, 4'b0000);
      for (int i = 0; i < EXIT_DLY; i++) step({tag, ".exit"}, 1'b0, 1'b0, 4'b0000, 4'b0000);
      check({tag, ".armed_state"}, 16'(state), 16'(S_ARMED));
   endtask

   initial begin
      logic         r_en;
      logic         r_sq;
      logic [N-1:0] r_mv;
      logic [N-1:0] r_mk;
      rst_n = 1'b0; enable = 1'b0; seq = 1'b0; mov = '0; zone_mask = '0;
      model_reset();
      #12;
      check_model("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // exit delay ignores motion, arms after EXIT_DLY cycles with empty trip record
      step("t2.arm", 1'b1, 1'b1, 4'b1111, 4'b0000);
      for (int i = 1; i < EXIT_DLY; i++) begin
         step("t2.exit", 1'b0, 1'b0, 4'b1111, 4'b0000);
         check("t2.in_exit", 16'(state), 16'(S_EXIT));
      end
      step("t2.done", 1'b0, 1'b0, 4'b0000, 4'b0000);
      check("t2.armed", 16'(state), 16'(S_ARMED));
      check("t2.trip", 16'(trip_zones), 16'h0000);

      // zone 2 trip runs entry delay into a bounded siren
      step("t3.trip", 1'b0, 1'b0, 4'b0100, 4'b0000);
      check("t3.entry", 16'(state), 16'(S_ENTRY));
      check("t3.tripz", 16'(trip_zones), 16'h0004);
      for (int i = 1; i < ENTRY_DLY; i++) step("t3.entry_wait", 1'b0, 1'b0, 4'b0000, 4'b0000);
      check("t3.still_entry", 16'(state), 16'(S_ENTRY));
      step("t3.alarm", 1'b0, 1'b0, 4'b0000, 4'b0000);
      check("t3.alarm_state", 16'(state), 16'(S_ALARM));
      check("t3.siren_on", 16'(siren), 16'h0001);
      for (int i = 1; i < SIREN_CYC; i++) step("t3.siren", 1'b0, 1'b0, 4'b0000, 4'b0000);
      check("t3.siren_last", 16'(siren), 16'h0001);
      step("t3.silent", 1'b0, 1'b0, 4'b0000, 4'b0000);
      check("t3.siren_off", 16'(siren), 16'h0000);
      check("t3.stay_alarm", 16'(state), 16'(S_ALARM));
      step("t3.disarm", 1'b1, 1'b1, 4'b0000, 4'b0000);
      check("t3.kept_trip", 16'(trip_zones), 16'h0004);

      // bypassed zone is ignored, an unmasked one still trips
      arm_and_wait("t4");
      for (int i = 0; i < 3; i++) step("t4.masked", 1'b0, 1'b0, 4'b0100, 4'b0100);
      check("t4.stay_armed", 16'(state), 16'(S_ARMED));
      step("t4.trip", 1'b0, 1'b0, 4'b0010, 4'b0100);
      check("t4.entry", 16'(state), 16'(S_ENTRY));
      check("t4.tripz", 16'(trip_zones), 16'h0002);

      // disarm on the very cycle the entry delay expires
      for (int i = 1; i < ENTRY_DLY; i++) step("t5.wait", 1'b0, 1'b0, 4'b0000, 4'b0000);
      step("t5.disarm", 1'b1, 1'b1, 4'b0000, 4'b0000);
      check("t5.unarmed", 16'(state), 16'(S_UNARMED));
      check("t5.no_siren", 16'(siren), 16'h0000);

      // zone 0 instant or delayed depending on build
      arm_and_wait("t6");
      step("t6.z0", 1'b0, 1'b0, 4'b0001, 4'b0000);
      check("t6.state", 16'(state), INSTANT ? 16'(S_ALARM) : 16'(S_ENTRY));
      check("t6.siren", 16'(siren), INSTANT ? 16'h0001 : 16'h0000);
      step("t6.disarm", 1'b1, 1'b1, 4'b0000, 4'b0000);

      // asynchronous reset in the middle of an entry delay
      arm_and_wait("t1");
      step("t1.trip", 1'b0, 1'b0, 4'b0010, 4'b0000);
      step("t1.wait", 1'b0, 1'b0, 4'b0000, 4'b0000);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("t1.state", 16'(state), 16'(S_UNARMED));
      check("t1.siren", 16'(siren), 16'h0000);
      check("t1.trip", 16'(trip_zones), 16'h0000);
      check("t1.armed", 16'(armed), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // random traffic against the model
      r_mk = '0;
      for (int i = 0; i < 4000; i++) begin
         r_en = ($urandom_range(0, 19) == 0);
         r_sq = ($urandom_range(0, 3) != 0);
         r_mv = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
         if ($urandom_range(0, 49) == 0) r_mk = N'($urandom);
         step("rand", r_en, r_sq, r_mv, r_mk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
